// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: FSM state encodings,
// idle line level and default frame geometry.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  localparam logic LINE_IDLE        = 1'b1;
  localparam int   DEF_CLKS_PER_BIT = 16;
  localparam int   DEF_DATA_BITS    = 8;

endpackage

// File: rtl/serial_rx_if.sv
// Parallel Valid/Ack byte bus between serial_rx (master) and its consumer.
// parity_err exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_rx_if #(
  parameter int DATA_BITS = serial_pkg::DEF_DATA_BITS
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ack;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;
`ifdef SERIAL_RX_PARITY_EN
  logic                 parity_err;
`endif

  modport master (
    output data, valid, frame_err, overrun, busy,
`ifdef SERIAL_RX_PARITY_EN
    output parity_err,
`endif
    input  ack
  );

  modport slave (
    input  data, valid, frame_err, overrun, busy,
`ifdef SERIAL_RX_PARITY_EN
    input  parity_err,
`endif
    output ack
  );
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous RxD line plus a falling-edge
// detector; all stages reset to the idle line level.
module rx_sync
  import serial_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_rxd,
  output logic o_level,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_meta <= LINE_IDLE;
      r_sync <= LINE_IDLE;
      r_prev <= LINE_IDLE;
    end else begin
      r_meta <= i_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;
endmodule

// File: rtl/serial_rx.sv
// Serial frame receiver: mid-bit sampling of start/data/stop bits, Valid/Ack
// delivery with overrun and framing-error reporting. Optional even-parity
// bit when SERIAL_RX_PARITY_EN is defined.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rxd,
  serial_rx_if.master bus
);
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     BITS_LAST = 4'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 w_level;
  logic                 w_fall;
  logic                 w_tick;
  logic                 w_frame_ok;
  logic                 w_frame_bad;
  logic                 w_accept;

  rx_sync u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_rxd     (i_rxd),
    .o_level   (w_level),
    .o_fall    (w_fall)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // w_tick marks the cycle in which the current bit is sampled.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_tick      = 1'b1;
          w_state_nxt = w_level ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_tick = 1'b1;
          if (r_bit_cnt == BITS_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        if (r_cnt == CNT_FULL) begin
          w_tick      = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_tick      = 1'b1;
          w_frame_ok  = w_level;
          w_frame_bad = ~w_level;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || r_state == ST_IDLE || w_tick) r_cnt <= '0;
    else                                            r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || r_state == ST_IDLE) r_bit_cnt <= '0;
    else if (r_state == ST_DATA && w_tick) r_bit_cnt <= r_bit_cnt + 1'b1;
  end

  // LSB arrives first, so new bits enter at the top and walk down.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_DATA && w_tick) r_shift <= {w_level, r_shift[DATA_BITS-1:1]};
  end

  assign w_accept = r_valid & bus.ack;

`ifdef SERIAL_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  function automatic logic parity_fail(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  always_ff @(posedge i_clk) begin
    if (r_state == ST_PARITY && w_tick) r_par_bit <= w_level;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)      r_parity_err <= 1'b0;
    else if (w_frame_ok) r_parity_err <= parity_fail(r_shift, r_par_bit);
    else if (w_accept)   r_parity_err <= 1'b0;
  end

  assign bus.parity_err = r_parity_err;
`endif

  // A completion coinciding with an accept counts as a fresh byte, not an overrun.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_frame_ok) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (w_accept)     r_overrun <= 1'b0;
        else if (r_valid) r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: doc/serial_rx.md
# serial_rx

Receive end of the team's asynchronous serial link: recovers 8N1 frames (start bit, DATA_BITS data bits LSB-first, one stop bit) from a single line, idle-high. It samples each bit at mid-bit by counting Clk cycles, presents the received byte on a parallel Valid/Ack handshake, and reports framing errors and overruns. It sits between the board's serial input pin and the datapath logic that consumes bytes.

## Interface
- CLKS_PER_BIT, default 16: Clk cycles per bit period; legal values are even and ≥ 4.
- DATA_BITS, default 8: data bits per frame, 5 to 8.
- Clk, input, 1: the single clock; all state updates on the rising edge.
- Reset_n, input, 1: synchronous, active-low reset, sampled on the Clk rising edge.
- RxD, input, 1: serial line, asynchronous to Clk, idle high.
- Data, output, DATA_BITS: last received byte; stable while Valid = 1.
- Valid, output, 1: byte available; held until accepted.
- Ack, input, 1: consumer accepts Data in any cycle where Valid = 1 and Ack = 1.
- FrameErr, output, 1: one-cycle pulse when the stop bit samples low.
- Overrun, output, 1: sticky; set when a frame completes while Valid = 1 and Ack = 0.
- Busy, output, 1: high in every state except IDLE.
- ParityErr, output, 1: present only with SERIAL_RX_PARITY_EN (see Configuration).

## Operation
- RxD passes through a two-flop synchronizer. Both stages reset to 1.
- The FSM has four states, in order: IDLE, START, DATA, STOP. A PARITY state sits between DATA and STOP only when the macro is defined.
- IDLE: a synchronized falling edge (previous sample 1, current sample 0) moves to START and clears the bit counter.
- START: waits CLKS_PER_BIT/2 cycles, then samples the line.
  - Sample 0: the start bit is valid; go to DATA.
  - Sample 1: false start; return to IDLE with no error reported.
- DATA: samples every CLKS_PER_BIT cycles. Each sample shifts into the MSB of the shift register, so data arrives LSB-first. After DATA_BITS samples, go to STOP (or PARITY).
- STOP: samples once, CLKS_PER_BIT cycles after the last data sample.
  - Sample 1: load Data from the shift register and set Valid.
  - Sample 0: pulse FrameErr for one cycle; Data and Valid are unchanged.
  - Either way, return to IDLE in the same cycle. The remaining half of the stop bit is treated as idle, which permits back-to-back frames.
- Handshake: Valid clears on the cycle after Valid and Ack are both high. Ack while Valid = 0 is ignored.
- Overrun: a frame completing while Valid = 1 and Ack = 0 overwrites Data and sets Overrun. Overrun stays set until the next accepted Ack.
- Simultaneous Ack and frame completion: new Data is loaded, Valid stays 1, and Overrun is not set.
- Reset_n = 0 mid-frame: the FSM returns to IDLE and the partial frame is discarded.

## Timing
- Reset values: Data = 0, Valid = 0, FrameErr = 0, Overrun = 0, Busy = 0, ParityErr = 0. Synchronizer stages and the edge-detect register reset to 1.
- RxD to synchronized sample: 2 Clk cycles.
- Bit sampling: relative to the first synchronized low, the start bit is sampled at cycle CLKS_PER_BIT/2 and data bit k at CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- Valid and FrameErr rise on the clock edge immediately after the stop sample.
- Accept: Data may change on the cycle after acceptance, or on the same cycle as a simultaneous completion.
- Throughput: one frame every (DATA_BITS + 2)·CLKS_PER_BIT cycles, with no dead cycles between frames.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one even-parity bit, CLKS_PER_BIT cycles after the last data sample.
  - ParityErr = 1 when the XOR of the data bits and the parity bit is 1. The frame is still delivered.
  - ParityErr is updated alongside Valid and clears on the accepting Ack.
  - Frame length becomes DATA_BITS + 3 bits.
- Not defined: no PARITY state and no ParityErr port. Frames are 8N1 as above.

## Structure
- Shared package serial_pkg holds:
  - FSM state encodings: IDLE = 0, START = 1, DATA = 2, PARITY = 3, STOP = 4, in a 3-bit field.
  - Idle line level (1).
  - Default CLKS_PER_BIT and DATA_BITS.
- Sub-module rx_sync: the two-flop synchronizer plus falling-edge detector. Outputs the synchronized level and a one-cycle fall pulse. All other logic stays in serial_rx.

## Test plan
- Reset, then send frame 0xA5 at CLKS_PER_BIT = 16 → Valid rises 1 cycle after the stop sample, Data = 0xA5, FrameErr = 0; Ack → Valid = 0 the next cycle.
- RxD low for 6 cycles then high (glitch) → return to IDLE; Valid, FrameErr and Busy all 0 within 10 cycles of the glitch.
- Frame 0x3C with the stop bit driven low → one-cycle FrameErr pulse, Valid stays 0, Data unchanged.
- Back-to-back 0x11 then 0x22 with Ack never asserted → Data = 0x22, Valid = 1, Overrun = 1; Ack → Valid = 0 and Overrun = 0.
- Assert Reset_n = 0 for 1 cycle during data bit 4 of 0xFF, then send 0x0F → only 0x0F is received.
- With SERIAL_RX_PARITY_EN, send 0x07 with parity bit 0 → Valid = 1, Data = 0x07, ParityErr = 1; send again with parity bit 1 → ParityErr = 0.
